// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the FETCH-stage sequencer.
//  fetch_state_t : BOOT / RUN / HALT / FAULT
//  BUBBLE        : all-zero word loaded into the fetch register on flush
//  DEF_RESET_PC  : default PC after reset (word-aligned)
package fetch_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [WORD_W-1:0] BUBBLE       = '0;
  localparam logic [WORD_W-1:0] DEF_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_pc_sel.sv
// fetch_pc_sel: combinational next-PC mux for the fetch stage.
//  i_pc          current PC
//  i_hold        keep the current PC
//  i_redirect    take the redirect target (word-aligned here)
//  i_redirect_pc raw redirect target
//  o_next_pc     selected next PC
module fetch_pc_sel
  import fetch_pkg::*;
(
  input  logic [WORD_W-1:0] i_pc,
  input  logic              i_hold,
  input  logic              i_redirect,
  input  logic [WORD_W-1:0] i_redirect_pc,
  output logic [WORD_W-1:0] o_next_pc
);
  // Low two bits are dropped so the PC stays word-aligned whatever decode sends.
  logic [WORD_W-1:0] w_aligned;
  assign w_aligned = i_redirect_pc & ~WORD_W'(3);

  always_comb begin
    o_next_pc = i_pc + WORD_W'(4);  // wraps naturally at 2^WORD_W
    if (i_hold)          o_next_pc = i_pc;
    else if (i_redirect) o_next_pc = w_aligned;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: FETCH-stage sequencer. Owns the PC register and produces the
// PC-enable / fetch-enable / fetch-flush controls for the fetch datapath.
//  clk, reset          clock (rising), async active-high reset
//  stallD              decode hazard: hold PC and fetch register
//  redirect/redirectPc taken branch/jump and its target
//  haltReq, resume     debug halt (level) and resume (pulse)
//  pcF, imemIdx        current PC and its instruction-memory word index
//  pcEn/fetchEn/fetchFlush  datapath controls (combinational)
//  halted, fault       HALT state / sticky out-of-range fault
//  fetchCount          saturating count of real instructions latched
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                IMEM_POWER = 18,
  parameter logic [WORD_W-1:0] RESET_PC   = DEF_RESET_PC,
  parameter int                CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stallD,
  input  logic                  redirect,
  input  logic [WORD_W-1:0]     redirectPc,
  input  logic                  haltReq,
  input  logic                  resume,
  output logic [WORD_W-1:0]     pcF,
  output logic [IMEM_POWER-1:0] imemIdx,
  output logic                  pcEn,
  output logic                  fetchEn,
  output logic                  fetchFlush,
  output logic                  halted,
  output logic                  fault,
  output logic [CNT_W-1:0]      fetchCount
);
  fetch_state_t      r_state, w_state_nxt;
  logic [WORD_W-1:0] r_pc, w_next_pc;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_out, w_pc_en, w_fetch_en, w_flush, w_redir_sel;

  // Out-of-range when any PC bit above the memory window is set. A memory
  // covering the whole address space can never fault.
  generate
    if (IMEM_POWER + 2 < WORD_W) begin : g_range
      assign w_out = |r_pc[WORD_W-1:IMEM_POWER+2];
    end else begin : g_no_range
      assign w_out = 1'b0;
    end
  endgenerate

  // Priority inside RUN: fault > redirect > halt > stall > advance.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_en     = 1'b0;
    w_fetch_en  = 1'b1;
    w_flush     = 1'b1;
    w_redir_sel = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        if (w_out) begin
          w_state_nxt = FAULT;           // illegal word never latched
        end else if (redirect) begin
          w_pc_en     = 1'b1;            // target loads even if halting
          w_redir_sel = 1'b1;
          if (haltReq) w_state_nxt = HALT;
        end else if (haltReq) begin
          w_state_nxt = HALT;
        end else if (stallD) begin
          w_fetch_en  = 1'b0;
          w_flush     = 1'b0;
        end else begin
          w_pc_en     = 1'b1;
          w_flush     = 1'b0;
        end
      end
      HALT: if (resume && !haltReq) w_state_nxt = RUN;
      FAULT: ;                            // sticky until reset
      default: w_state_nxt = BOOT;
    endcase
  end

  fetch_pc_sel u_pc_sel (
    .i_pc          (r_pc),
    .i_hold        (~w_pc_en),
    .i_redirect    (w_redir_sel),
    .i_redirect_pc (redirectPc),
    .o_next_pc     (w_next_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pc_en) r_pc <= w_next_pc;
      if (w_fetch_en && !w_flush && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign pcF        = r_pc;
  assign imemIdx    = r_pc[IMEM_POWER+1:2];
  assign pcEn       = w_pc_en;
  assign fetchEn    = w_fetch_en;
  assign fetchFlush = w_flush;
  assign halted     = (r_state == HALT);
  assign fault      = (r_state == FAULT);
  assign fetchCount = r_cnt;
endmodule
